// File: rtl/fdet_pkg.sv
// Shared speed codes, detector states and default half-period timing for the PWM frequency detector.
// Pure declarations; no logic, latency or flow control.
package fdet_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEAS   = 2'd1,
        LOCKED = 2'd2
    } fdet_state_e;

    // Code bit 1 drives speed1 and code bit 0 drives speed2.
    localparam logic [1:0] CODE_10 = 2'b10;
    localparam logic [1:0] CODE_00 = 2'b00;
    localparam logic [1:0] CODE_01 = 2'b01;
    localparam logic [1:0] CODE_11 = 2'b11;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_HP_10    = 5;
    localparam int DEF_HP_00    = 25;
    localparam int DEF_HP_01    = 125;
    localparam int DEF_HP_11    = 25525;
    localparam int DEF_TOL      = 1;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_TIMEOUT  = 32767;

endpackage

// File: rtl/fdet_sync_edge.sv
// Two-flop synchronizer plus a delay flop; flags any level change on the synchronized input.
// Edge is valid 2 clk50 edges after the input changes; no backpressure.
module fdet_sync_edge (
    input  logic clk50,
    input  logic rst_n,
    input  logic pwm_i,
    output logic edge_o,
    output logic level_o
);

    logic s1_q;
    logic s2_q;
    logic dly_q;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dly_q <= 1'b0;
        end else begin
            s1_q  <= pwm_i;
            s2_q  <= s1_q;
            dly_q <= s2_q;
        end
    end

    assign edge_o  = s2_q ^ dly_q;
    assign level_o = s2_q;

endmodule

// File: rtl/pwm_freq_detect.sv
// Measures the half-period of pwm_in in clk50 cycles and decodes/locks the 2-bit speed code; optional chg_irq under FDET_CHANGE_IRQ_EN.
// meas/meas_valid register 3 clk50 edges after pwm_in changes; free-running sink, no backpressure.
module pwm_freq_detect
    import fdet_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int HP_10    = DEF_HP_10,
    parameter int HP_00    = DEF_HP_00,
    parameter int HP_01    = DEF_HP_01,
    parameter int HP_11    = DEF_HP_11,
    parameter int TOL      = DEF_TOL,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             clk50,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic             speed1,
    output logic             speed2,
    output logic             locked,
    output logic [CNT_W-1:0] meas,
    output logic             meas_valid,
    output logic             stall
`ifdef FDET_CHANGE_IRQ_EN
    ,
    output logic             chg_irq
`endif
);

    localparam int              MC_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  LOCK_N  = MC_W'(LOCK_CNT);

    logic edge_w;
    logic pwm_lvl_unused;

    fdet_sync_edge u_sync (
        .clk50   (clk50),
        .rst_n   (rst_n),
        .pwm_i   (pwm_in),
        .edge_o  (edge_w),
        .level_o (pwm_lvl_unused)
    );

    fdet_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic             mvld_q, mvld_d;
    logic [1:0]       cand_q, cand_d;
    logic [MC_W-1:0]  mcnt_q, mcnt_d;
    logic [1:0]       spd_q, spd_d;
    logic             locked_q, locked_d;
    logic             stall_q, stall_d;

    // One extra bit of signed headroom keeps |v - hp| exact for any counter value.
    function automatic logic near(input logic [CNT_W-1:0] v, input int hp);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, v}) - $signed((CNT_W+1)'(hp));
        return (diff <= $signed((CNT_W+1)'(TOL))) && (diff >= -$signed((CNT_W+1)'(TOL)));
    endfunction

    logic       hit;
    logic [1:0] code;

    always_comb begin
        hit  = 1'b1;
        code = CODE_00;
        if      (near(cnt_q, HP_10)) code = CODE_10;
        else if (near(cnt_q, HP_00)) code = CODE_00;
        else if (near(cnt_q, HP_01)) code = CODE_01;
        else if (near(cnt_q, HP_11)) code = CODE_11;
        else                         hit  = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        meas_d   = meas_q;
        mvld_d   = 1'b0;
        cand_d   = cand_q;
        mcnt_d   = mcnt_q;
        spd_d    = spd_q;
        locked_d = locked_q;
        stall_d  = stall_q;

        if (edge_w)                cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

        // An edge always wins over a coincident timeout.
        if (edge_w) begin
            stall_d = 1'b0;
            if (state_q == IDLE) begin
                state_d = MEAS;
            end else begin
                meas_d = cnt_q;
                mvld_d = 1'b1;
                if (!hit) begin
                    mcnt_d   = '0;
                    locked_d = 1'b0;
                    state_d  = MEAS;
                end else if (state_q == LOCKED) begin
                    if (code != spd_q) begin
                        locked_d = 1'b0;
                        state_d  = MEAS;
                        cand_d   = code;
                        mcnt_d   = MC_W'(1);
                    end
                end else begin
                    cand_d = code;
                    mcnt_d = (code == cand_q) ? mcnt_q + 1'b1 : MC_W'(1);
                    if (mcnt_d == LOCK_N) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        spd_d    = code;
                    end
                end
            end
        end else if (cnt_q == TO_VAL) begin
            stall_d  = 1'b1;
            locked_d = 1'b0;
            state_d  = IDLE;
            mcnt_d   = '0;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_W'(1);
            meas_q   <= '0;
            mvld_q   <= 1'b0;
            cand_q   <= CODE_00;
            mcnt_q   <= '0;
            spd_q    <= CODE_00;
            locked_q <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            meas_q   <= meas_d;
            mvld_q   <= mvld_d;
            cand_q   <= cand_d;
            mcnt_q   <= mcnt_d;
            spd_q    <= spd_d;
            locked_q <= locked_d;
            stall_q  <= stall_d;
        end
    end

`ifdef FDET_CHANGE_IRQ_EN
    // The very first lock after reset counts as a lock to a new code.
    logic ever_q;
    logic chg_q, chg_d;

    always_comb begin
        chg_d = (locked_q & ~locked_d) |
                (~locked_q & locked_d & (~ever_q | (spd_d != spd_q)));
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            ever_q <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            ever_q <= ever_q | locked_d;
            chg_q  <= chg_d;
        end
    end

    assign chg_irq = chg_q;
`endif

    assign speed1     = spd_q[1];
    assign speed2     = spd_q[0];
    assign locked     = locked_q;
    assign meas       = meas_q;
    assign meas_valid = mvld_q;
    assign stall      = stall_q;

endmodule

// File: tb/tb_pwm_freq_detect.sv
// Scoreboard bench for pwm_freq_detect: a toggle-level reference model queues expected outputs, a monitor checks them.
module tb_pwm_freq_detect;

    localparam int HP10 = 5;
    localparam int HP00 = 25;
    localparam int HP01 = 125;
    localparam int HP11 = 400;
    localparam int TOL  = 1;
    localparam int LCK  = 4;
    localparam int TO   = 1000;

    logic        clk50  = 1'b0;
    logic        rst_n  = 1'b0;
    logic        pwm_in = 1'b0;
    logic        speed1, speed2, locked, meas_valid, stall;
    logic [15:0] meas;
`ifdef FDET_CHANGE_IRQ_EN
    logic        chg_irq;
`endif

    pwm_freq_detect #(
        .CNT_W(16), .HP_10(HP10), .HP_00(HP00), .HP_01(HP01), .HP_11(HP11),
        .TOL(TOL), .LOCK_CNT(LCK), .TIMEOUT(TO)
    ) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .speed1     (speed1),
        .speed2     (speed2),
        .locked     (locked),
        .meas       (meas),
        .meas_valid (meas_valid),
        .stall      (stall)
`ifdef FDET_CHANGE_IRQ_EN
        ,
        .chg_irq    (chg_irq)
`endif
    );

    always #5 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected (cycle %0d)", nm, cyc);
    endtask

    typedef struct {
        int       cyc;
        int       meas;
        bit       lk;
        bit [1:0] spd;
    } exp_t;

    exp_t mq[$];
    int   stq[$];
    int   cq[$];

    // Reference model: state 0 = no edge reference, 1 = measuring, 2 = locked.
    int       m_state, m_cand, m_cnt, last_t;
    bit       m_locked, m_ever;
    bit [1:0] m_spd;

    task automatic model_init();
        m_state = 0; m_cand = 0; m_cnt = 0;
        m_locked = 0; m_ever = 0; m_spd = 2'b00;
    endtask

    function automatic void classify(input int v, output bit hit, output int code);
        int hp, d;
        hit  = 0;
        code = 0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       hp = HP10;
                1:       hp = HP00;
                2:       hp = HP01;
                default: hp = HP11;
            endcase
            d = (v > hp) ? v - hp : hp - v;
            if (!hit && d <= TOL) begin
                hit = 1;
                case (i)
                    0:       code = 2;
                    1:       code = 0;
                    2:       code = 1;
                    default: code = 3;
                endcase
            end
        end
    endfunction

    task automatic toggle_model(input int t);
        int   n, code;
        bit   hit;
        exp_t e;
        n      = t - last_t;
        last_t = t;
        if (m_state == 0) begin
            m_state = 1;
            return;
        end
        classify(n, hit, code);
        if (!hit) begin
            if (m_locked) cq.push_back(t + 3);
            m_locked = 0; m_cnt = 0; m_state = 1;
        end else if (m_state == 2) begin
            if (code != int'(m_spd)) begin
                m_locked = 0; cq.push_back(t + 3);
                m_state = 1; m_cand = code; m_cnt = 1;
            end
        end else begin
            if (code == m_cand) m_cnt++;
            else begin m_cand = code; m_cnt = 1; end
            if (m_cnt == LCK) begin
                if (!m_ever || code != int'(m_spd)) cq.push_back(t + 3);
                m_state = 2; m_locked = 1; m_ever = 1; m_spd = 2'(code);
            end
        end
        e.cyc = t + 3; e.meas = n; e.lk = m_locked; e.spd = m_spd;
        mq.push_back(e);
    endtask

    // Wait n cycles since the previous toggle, then toggle pwm_in.
    task automatic gap(input int n);
        if (n > TO) begin
            stq.push_back(last_t + 3 + TO);
            if (m_locked) cq.push_back(last_t + 3 + TO);
            m_locked = 0; m_state = 0; m_cnt = 0;
        end
        repeat (n) @(posedge clk50);
        #1 pwm_in = ~pwm_in;
        toggle_model(cyc);
    endtask

    task automatic do_reset();
        @(posedge clk50);
        #2 rst_n = 1'b0;
        pwm_in = 1'b0;
        #1;
        chk("rst_meas", int'(meas), 0);
        chk("rst_meas_valid", int'(meas_valid), 0);
        chk("rst_speed1", int'(speed1), 0);
        chk("rst_speed2", int'(speed2), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_stall", int'(stall), 0);
        mq.delete(); stq.delete(); cq.delete();
        model_init();
        repeat (2) @(posedge clk50);
        #1 rst_n = 1'b1;
        last_t = cyc;
    endtask

    exp_t mon_e;
    int   mon_c;
    bit   stall_p;

    always @(negedge clk50) begin
        if (!rst_n) begin
            stall_p <= 1'b0;
        end else begin
            if (meas_valid) begin
                if (mq.size() == 0) unexpected("meas_valid");
                else begin
                    mon_e = mq.pop_front();
                    chk("meas_cycle", cyc, mon_e.cyc);
                    chk("meas", int'(meas), mon_e.meas);
                    chk("locked", int'(locked), int'(mon_e.lk));
                    chk("speed", int'({speed1, speed2}), int'(mon_e.spd));
                end
            end
            if (stall && !stall_p) begin
                if (stq.size() == 0) unexpected("stall");
                else begin
                    mon_c = stq.pop_front();
                    chk("stall_cycle", cyc, mon_c);
                    chk("stall_locked", int'(locked), 0);
                end
            end
`ifdef FDET_CHANGE_IRQ_EN
            if (chg_irq) begin
                if (cq.size() == 0) unexpected("chg_irq");
                else begin
                    mon_c = cq.pop_front();
                    chk("chg_irq_cycle", cyc, mon_c);
                end
            end
`endif
            stall_p <= stall;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, len, hp;
        model_init();
        last_t = 0;
        do_reset();

        // Code 00 lock
        gap(3);
        repeat (6) gap(25);
        // Code 10 at 5 and 6, then 7 drops lock
        repeat (4) gap(5);
        repeat (2) gap(6);
        repeat (2) gap(7);
        // Code 01 then code 11, unmatched drop and same-code relock
        repeat (5) gap(125);
        repeat (5) gap(HP11);
        gap(200);
        repeat (4) gap(HP11);
        // Stall, resume, then an edge coinciding with the timeout
        gap(TO + 50);
        repeat (5) gap(25);
        gap(TO);
        repeat (2) gap(25);
        // Asynchronous reset mid-measurement, then a fresh start
        do_reset();
        gap(3);
        repeat (6) gap(25);

        for (int k = 0; k < 40; k++) begin
            r   = $urandom_range(0, 3);
            len = $urandom_range(1, 6);
            case (r)
                0:       hp = HP10;
                1:       hp = HP00;
                2:       hp = HP01;
                default: hp = HP11;
            endcase
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 7) == 0) gap($urandom_range(2, 450));
                else                           gap(hp + $urandom_range(0, 2) - 1);
            end
        end

        repeat (10) @(posedge clk50);
        #1;
        chk("drain_meas_queue", mq.size(), 0);
        chk("drain_stall_queue", stq.size(), 0);
`ifdef FDET_CHANGE_IRQ_EN
        chk("drain_chg_queue", cq.size(), 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
